// File: rtl/pio_pkg.sv
// pio_pkg: register map addresses and bus width shared by the PIO output block.
package pio_pkg;
  localparam int RDATA_W = 32;
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MODE   = 3'd1;
  localparam logic [2:0] ADDR_DIV    = 3'd2;
  localparam logic [2:0] ADDR_SET    = 3'd3;
  localparam logic [2:0] ADDR_CLR    = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
endpackage

// File: rtl/pio_clkdiv.sv
// pio_clkdiv: half-period down-counter and phase toggle for the divided clock outputs.
module pio_clkdiv #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  input  logic             div_load,
  output logic             phase
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic phase_q, phase_d;
  // Idle holds the reload value, so the first running edge already counts from DIV.
  always_comb begin
    cnt_d   = (!run || div_load || cnt_q == '0) ? div : cnt_q - 1'b1;
    phase_d = !run ? 1'b0 : (!div_load && cnt_q == '0) ? ~phase_q : phase_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end
  assign phase = phase_q;
endmodule

// File: rtl/pio_out_clkdiv.sv
// pio_out_clkdiv: Avalon-MM PIO output with per-bit divided-clock mode.
// Define PIO_BITSET_EN to enable atomic SET/CLR writes to DATA.
module pio_out_clkdiv
  import pio_pkg::*;
#(
  parameter int          WIDTH      = 2,
  parameter int          DIV_W      = 16,
  parameter logic [31:0] RESET_DATA = 32'd0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [2:0]         address,
  input  logic [31:0]        writedata,
  output logic [RDATA_W-1:0] readdata,
  output logic [WIDTH-1:0]   out_port
);
`ifdef PIO_BITSET_EN
  localparam bit BITSET_EN = 1'b1;
`else
  localparam bit BITSET_EN = 1'b0;
`endif
  logic [WIDTH-1:0] data_q, data_d, mode_q, mode_d, out_q, out_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic wr, run, phase, div_load;
  assign wr       = chipselect & ~write_n;
  assign run      = |mode_q;
  assign div_load = wr && address == ADDR_DIV;
  always_comb begin
    data_d = data_q;
    if (wr && address == ADDR_DATA) data_d = writedata[WIDTH-1:0];
    if (BITSET_EN && wr && address == ADDR_SET) data_d = data_q | writedata[WIDTH-1:0];
    if (BITSET_EN && wr && address == ADDR_CLR) data_d = data_q & ~writedata[WIDTH-1:0];
    mode_d = (wr && address == ADDR_MODE) ? writedata[WIDTH-1:0] : mode_q;
    div_d  = div_load ? writedata[DIV_W-1:0] : div_q;
    out_d  = (mode_q & {WIDTH{phase}}) ^ data_q;
  end
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0] = data_q;
      ADDR_MODE:   readdata[WIDTH-1:0] = mode_q;
      ADDR_DIV:    readdata[DIV_W-1:0] = div_q;
      ADDR_STATUS: readdata[0]         = run;
      default:     readdata            = '0;
    endcase
  end
  // The divider sees the incoming DIV so a write restarts the half-period on its own edge.
  pio_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .div      (div_d),
    .div_load (div_load),
    .phase    (phase)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_DATA[WIDTH-1:0];
      mode_q <= '0;
      div_q  <= '0;
      out_q  <= RESET_DATA[WIDTH-1:0];
    end else begin
      data_q <= data_d;
      mode_q <= mode_d;
      div_q  <= div_d;
      out_q  <= out_d;
    end
  end
  assign out_port = out_q;
endmodule

// File: tb/tb_pio_out_clkdiv.sv
// tb_pio_out_clkdiv: directed register-map vectors plus divided-clock timing sequences.
module tb_pio_out_clkdiv;
  import pio_pkg::*;
  logic        clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, write_n = 1'b1;
  logic [2:0]  address = 3'd0;
  logic [31:0] writedata = 32'd0, readdata;
  logic [1:0]  out_port;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  pio_out_clkdiv dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .write_n    (write_n),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );
  typedef struct {
    bit          we;
    logic [2:0]  a;
    logic [31:0] d;
    logic [2:0]  ra;
    logic [31:0] erd;
    logic [1:0]  eout;
  } vec_t;
  vec_t v[11];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask
  task automatic rd(input logic [2:0] a, input string nm, input logic [31:0] exp);
    address = a;
    #1;
    chk(nm, readdata, exp);
  endtask
  initial begin
    logic [31:0] bs_set, bs_clr;
`ifdef PIO_BITSET_EN
    bs_set = 32'h3;
    bs_clr = 32'h2;
`else
    bs_set = 32'h1;
    bs_clr = 32'h1;
`endif
    v[0]  = '{0, 3'd0, 32'h0,        3'd0, 32'h0,    2'h0};
    v[1]  = '{1, 3'd0, 32'h3,        3'd0, 32'h3,    2'h0};
    v[2]  = '{0, 3'd0, 32'h0,        3'd0, 32'h3,    2'h3};
    v[3]  = '{1, 3'd2, 32'h12345,    3'd2, 32'h2345, 2'h3};
    v[4]  = '{1, 3'd6, 32'hFF,       3'd6, 32'h0,    2'h3};
    v[5]  = '{1, 3'd1, 32'hFFFFFFFC, 3'd1, 32'h0,    2'h3};
    v[6]  = '{0, 3'd0, 32'h0,        3'd5, 32'h0,    2'h3};
    v[7]  = '{1, 3'd3, 32'hF,        3'd3, 32'h0,    2'h3};
    v[8]  = '{0, 3'd0, 32'h0,        3'd7, 32'h0,    2'h3};
    v[9]  = '{1, 3'd0, 32'hFFFFFFFE, 3'd0, 32'h2,    2'h3};
    v[10] = '{0, 3'd0, 32'h0,        3'd0, 32'h2,    2'h2};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {30'd0, out_port}, 32'h0);
    rd(ADDR_STATUS, "reset_status", 32'h0);
    rd(ADDR_DIV, "reset_div", 32'h0);
    @(negedge clk) reset_n = 1'b1;
    step;
    chk("post_release_out", {30'd0, out_port}, 32'h0);
    for (int i = 0; i < 11; i++) begin
      if (v[i].we) wr(v[i].a, v[i].d);
      else step;
      chk($sformatf("vec%0d_out", i), {30'd0, out_port}, {30'd0, v[i].eout});
      rd(v[i].ra, $sformatf("vec%0d_rd", i), v[i].erd);
    end
    wr(ADDR_DATA, 32'h1);
    step;
    wr(ADDR_SET, 32'h2);
    step;
    rd(ADDR_DATA, "set_data", bs_set);
    chk("set_out", {30'd0, out_port}, bs_set);
    wr(ADDR_CLR, 32'h1);
    step;
    rd(ADDR_DATA, "clr_data", bs_clr);
    rd(ADDR_SET, "set_rd0", 32'h0);
    rd(ADDR_CLR, "clr_rd0", 32'h0);
    wr(ADDR_DATA, 32'h0);
    wr(ADDR_DIV, 32'h4);
    wr(ADDR_MODE, 32'h1);
    rd(ADDR_STATUS, "div4_status", 32'h1);
    for (int k = 1; k <= 30; k++) begin
      step;
      chk($sformatf("div4_k%0d", k), {30'd0, out_port}, ((k - 1) / 5) % 2);
    end
    wr(ADDR_MODE, 32'h0);
    wr(ADDR_MODE, 32'h1);
    repeat (6) step;
    wr(ADDR_DIV, 32'h9);
    chk("divwr_at_edge", {30'd0, out_port}, 32'h1);
    for (int k = 1; k <= 21; k++) begin
      step;
      chk($sformatf("divwr_k%0d", k), {30'd0, out_port}, (k <= 10) ? 32'h1 : (k <= 20) ? 32'h0 : 32'h1);
    end
    wr(ADDR_MODE, 32'h0);
    wr(ADDR_DIV, 32'h0);
    wr(ADDR_DATA, 32'h2);
    wr(ADDR_MODE, 32'h3);
    for (int k = 1; k <= 8; k++) begin
      step;
      chk($sformatf("div0_k%0d", k), {30'd0, out_port}, (k % 2 == 1) ? 32'h2 : 32'h1);
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrun_reset_out", {30'd0, out_port}, 32'h0);
    rd(ADDR_MODE, "midrun_reset_mode", 32'h0);
    rd(ADDR_DATA, "midrun_reset_data", 32'h0);
    @(negedge clk) reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step;
      chk($sformatf("idle_k%0d", k), {30'd0, out_port}, 32'h0);
    end
    wr(ADDR_MODE, 32'h1);
    step;
    chk("resume_k1", {30'd0, out_port}, 32'h0);
    step;
    chk("resume_k2", {30'd0, out_port}, 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
